alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered, multi-cycle successor to the team's combinational 4-bit ALU.
- Adds the following over that ALU:
  - WIDTH parameter.
  - 3-bit opcode space: add, sub, and, or, xor, shifts, and a shift-add multiply.
  - Status flags.
  - start/busy/done handshake.
- Sits between a simple controller/sequencer and a register file. Operands and opcode are captured on start; the result is held until the next completed operation.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only when busy=0.
- A, input, WIDTH, operand A, captured on accepted start.
- B, input, WIDTH, operand B, captured on accepted start.
- sel, input, 3, opcode, captured on accepted start.
- result, output, WIDTH, registered result.
- carry_out, output, 1, carry / borrow / shift-out / multiply-high-nonzero.
- zero, output, 1, result == 0.
- overflow, output, 1, signed overflow (add/sub only, else 0).
- busy, output, 1, operation in progress; start ignored.
- done, output, 1, one-cycle pulse: result and flags updated this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - result, carry_out, zero, overflow, busy, done = 0.
  - FSM to IDLE; multiply counter and accumulators cleared.
  - Takes effect immediately, including mid-multiply: the operation is aborted and no done is produced.
- Opcodes (unsigned unless noted):
  - 000 add: result = A+B mod 2^WIDTH; carry_out = bit WIDTH of the sum; overflow = signed add overflow.
  - 001 sub: result = A-B mod 2^WIDTH; carry_out = 1 if A<B (borrow); overflow = signed sub overflow.
  - 010 and, 011 or, 100 xor: carry_out = 0, overflow = 0.
  - 101 shl: result = A<<1, LSB = 0; carry_out = A[WIDTH-1]. B is ignored.
  - 110 shr: result = A>>1 logical; carry_out = A[0]. B is ignored.
  - 111 mul: full 2*WIDTH product P; result = P[WIDTH-1:0]; carry_out = |P[2*WIDTH-1:WIDTH]; overflow = 0.
  - zero = (result == 0) for every opcode.
- FSM states: IDLE, MUL, DONE.
  - IDLE: on a clk edge with start=1, capture A, B, sel.
    - Ops 000-110: result and flags are written at that same edge; go to DONE. Latency is 1 cycle.
    - Op 111: go to MUL, busy=1, counter=0, accumulator=0.
  - MUL:
    - One multiplier bit per cycle, LSB first.
    - Add the shifted multiplicand to the accumulator when the bit is 1.
    - After WIDTH iterations, write result and flags, then go to DONE.
    - busy=1 for exactly WIDTH cycles.
    - done is asserted WIDTH+1 cycles after the start edge.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
    - A start present during the DONE cycle is ignored.
    - The earliest accepted back-to-back start is the cycle after DONE, so there is a 2-cycle minimum issue interval.
- Handshake and hold rules:
  - start while busy=1 is ignored; no queuing.
  - A, B and sel changes after capture have no effect on the operation in flight.
  - result and flags hold their values between done pulses. They change only at done, or to 0 on reset.
- Width rules:
  - All arithmetic wraps modulo 2^WIDTH.
  - The internal adder is WIDTH+1 bits wide.
  - The multiply accumulator is 2*WIDTH bits wide.

Test Plan:
- Reset/idle: assert rst_n=0 -> all outputs 0. Release reset and hold start=0 for 10 cycles -> busy=0, done=0, result stays 0.
- Add/sub (WIDTH=8):
  - A=0x7F, B=0x01, sel=000, start -> after 1 cycle: result=0x80, carry=0, overflow=1, zero=0, done pulse.
  - A=0x03, B=0x05, sel=001 -> result=0xFE, carry=1, overflow=0.
- Logic/shift:
  - A=0xF0, B=0x0F, sel=010 -> result=0x00, zero=1.
  - sel=100 -> result=0xFF.
  - A=0x81, sel=101 -> result=0x02, carry=1.
  - sel=110 -> result=0x40, carry=1.
- Multiply:
  - A=0x0C, B=0x0B, sel=111 -> busy high 8 cycles, done at cycle 9, result=0x84, carry=0.
  - A=0xFF, B=0xFF -> result=0x01, carry=1.
- Hold/ignore: during a multiply, change A/B/sel and pulse start -> the original product is delivered with exactly one done; the extra start produces no response.
- Abort: assert rst_n=0 at cycle 4 of a multiply -> outputs 0 immediately, no done. A new add issued after reset completes normally.

Source files
------------

// File: rtl/alu_seq_if.sv
// Controller-to-ALU bus for alu_seq: operand/opcode request plus registered result,
// flags and the start/busy/done handshake.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, sel,
    input  result, carry_out, zero, overflow, busy, done
  );

  modport slave (
    input  start, a, b, sel,
    output result, carry_out, zero, overflow, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle add/sub/logic/shift ops and a WIDTH-cycle
// shift-add multiply, with status flags and a start/busy/done handshake.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [2*WIDTH-1:0] acc_next;

  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};

  // Single-cycle ops evaluated straight from the bus so they land on the capture edge.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.sel)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b001: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b010: alu_res = bus.a & bus.b;
      3'b011: alu_res = bus.a | bus.b;
      3'b100: alu_res = bus.a ^ bus.b;
      3'b101: {alu_c, alu_res} = {bus.a, 1'b0};
      3'b110: {alu_res, alu_c} = {1'b0, bus.a};
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.sel == 3'b111) begin
            state_d  = StMul;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            carry_d  = alu_c;
            ovf_d    = alu_v;
            zero_d   = (alu_res == '0);
          end
        end
      end
      StMul: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          result_d = acc_next[WIDTH-1:0];
          carry_d  = |acc_next[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          zero_d   = (acc_next[WIDTH-1:0] == '0);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = (state_q == StMul);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes hand-computed expectations, a negedge
// monitor pops and checks them on every done pulse and checks hold between pulses.
module tb_alu_seq;

  localparam int unsigned W = 8;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
    int         due;
    int         blen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   last_issue = 0;
  exp_t sb[$];

  logic [7:0] hold_res = '0;
  logic       hold_c = 1'b0, hold_z = 1'b0, hold_v = 1'b0;
  int         run = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pop on done, otherwise require outputs to hold their last delivered values.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_res = '0; hold_c = 1'b0; hold_z = 1'b0; hold_v = 1'b0;
      run = 0;
    end else begin
      if (bus.busy) run++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, 32'(bus.result), 32'(e.res));
          chk({e.name, "_carry"}, 32'(bus.carry_out), 32'(e.c));
          chk({e.name, "_zero"}, 32'(bus.zero), 32'(e.z));
          chk({e.name, "_ovf"}, 32'(bus.overflow), 32'(e.v));
          chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
          chk({e.name, "_busy_len"}, 32'(run), 32'(e.blen));
          hold_res = e.res; hold_c = e.c; hold_z = e.z; hold_v = e.v;
        end
        run = 0;
      end else begin
        chk("hold_result", 32'(bus.result), 32'(hold_res));
        chk("hold_flags", {29'd0, bus.carry_out, bus.zero, bus.overflow},
            {29'd0, hold_c, hold_z, hold_v});
      end
    end
  end

  task automatic issue(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] s, input logic [7:0] r,
                       input logic c, input logic z, input logic v);
    exp_t e;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sel = s; bus.start = 1'b1;
    last_issue = cyc;
    e.name = name; e.res = r; e.c = c; e.z = z; e.v = v;
    e.due  = cyc + 1 + ((s == 3'b111) ? int'(W) : 0);
    e.blen = (s == 3'b111) ? int'(W) : 0;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_outs"}, {22'd0, bus.result, bus.carry_out, bus.zero, bus.overflow,
        bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0;
    #1 rst_n = 1'b0;
    #12 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    chk("idle_result", 32'(bus.result), 32'd0);

    issue("add_ovf",   8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b0, 1'b1); drain();
    issue("add_carry", 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0); drain();
    issue("sub_borrow",8'h03, 8'h05, 3'b001, 8'hFE, 1'b1, 1'b0, 1'b0); drain();
    issue("sub_ovf",   8'h80, 8'h01, 3'b001, 8'h7F, 1'b0, 1'b0, 1'b1); drain();
    issue("and",       8'hF0, 8'h0F, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0); drain();
    issue("or",        8'h50, 8'h0A, 3'b011, 8'h5A, 1'b0, 1'b0, 1'b0); drain();
    issue("xor",       8'hF0, 8'h0F, 3'b100, 8'hFF, 1'b0, 1'b0, 1'b0); drain();
    issue("shl",       8'h81, 8'h0F, 3'b101, 8'h02, 1'b1, 1'b0, 1'b0); drain();
    issue("shr",       8'h81, 8'h0F, 3'b110, 8'h40, 1'b1, 1'b0, 1'b0); drain();
    issue("mul_0c0b",  8'h0C, 8'h0B, 3'b111, 8'h84, 1'b0, 1'b0, 1'b0); drain();
    issue("mul_ffff",  8'hFF, 8'hFF, 3'b111, 8'h01, 1'b1, 1'b0, 1'b0); drain();
    issue("mul_zero",  8'h00, 8'h05, 3'b111, 8'h00, 1'b0, 1'b1, 1'b0); drain();

    // Inputs change and start pulses while busy and during DONE: exactly one response.
    issue("mul_hold",  8'h0D, 8'h07, 3'b111, 8'h5B, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.sel = 3'b000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.sel = 3'b101; bus.a = 8'h00;
    for (int i = 0; i < 40 && cyc < last_issue + 1 + int'(W); i++) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    // Abort a multiply with reset at its fourth busy cycle.
    issue("mul_abort", 8'h0C, 8'h0B, 3'b111, 8'h84, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1 chk_all_zero("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue("add_after", 8'h10, 8'h20, 3'b000, 8'h30, 1'b0, 1'b0, 1'b0); drain();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d",
             passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
